axi_lite_regbank_slave: RTL and testbench

AXI4-Lite slave endpoint holding a bank of NUM_REGS memory-mapped, software-writable registers. It is the responder counterpart to the team's AXI-Lite master: it accepts single-beat reads and writes with byte strobes and returns OKAY/SLVERR responses. It exposes every register's contents, plus a per-register write strobe, to the surrounding logic.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_regbank.sv | 57 +++++
 rtl/axi_lite_regbank_slave.sv | 177 +++++++++++++++++
 tb/tb_axi_lite_regbank_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write side: AW and W may arrive in either order or together.
  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_HAVE_ADDR = 2'd1,
    WR_HAVE_DATA = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_t;

  // Read side: address accepted, then data held until rready.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_regbank.sv
// Register storage: byte-strobed write port, registered read port, per-register write pulse.
// Latency: write visible on reg_q and wr_pulse one edge after wr_en; rd_data one edge after rd_en.
// Backpressure: none; caller gates wr_en/rd_en, rd_data holds until the next rd_en.
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic                           rd_en,
  input  logic                           rd_hit,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  assign reg_q = regs;

  // Byte-lane merge of the write data into the selected register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // One-cycle notification per committed write, raised even with an all-zero strobe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_en) wr_pulse[wr_idx] <= 1'b1;
    end
  end

  // Read sample uses the pre-update array, so a same-edge write is not seen.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? regs[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/axi_lite_regbank_slave.sv
// AXI4-Lite slave exposing NUM_REGS software-writable registers with byte strobes.
// Latency: bvalid/reg_q one cycle after the later AW/W handshake; rvalid one cycle after AR.
// Backpressure: one outstanding write and one read; readies drop while a response waits.
module axi_lite_regbank_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;

  logic aw_hs, w_hs, ar_hs, wr_commit;

  logic [ADDR_WIDTH-1:0] wr_addr_eff, aw_word, ar_word;
  logic [DATA_WIDTH-1:0] wr_data_eff;
  logic [STRB_W-1:0]     wr_strb_eff;
  logic                  aw_hit, ar_hit;

  // Readies come from state only, never from the matching valid.
  assign awready = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_DATA);
  assign wready  = (wr_state == WR_IDLE) || (wr_state == WR_HAVE_ADDR);
  assign bvalid  = (wr_state == WR_RESP);
  assign arready = (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_RESP);
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Whichever half arrived earlier comes from its capture register, the other is live.
  assign wr_addr_eff = (wr_state == WR_HAVE_ADDR) ? aw_addr_q : awaddr;
  assign wr_data_eff = (wr_state == WR_HAVE_DATA) ? w_data_q  : wdata;
  assign wr_strb_eff = (wr_state == WR_HAVE_DATA) ? w_strb_q  : wstrb;

  assign aw_word = wr_addr_eff >> ADDR_LSB;
  assign ar_word = araddr >> ADDR_LSB;
  assign aw_hit  = aw_word < ADDR_WIDTH'(NUM_REGS);
  assign ar_hit  = ar_word < ADDR_WIDTH'(NUM_REGS);

  // Write FSM next state; commit fires on the transition into WR_RESP.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end else if (aw_hs) begin
          wr_state_nxt = WR_HAVE_ADDR;
        end else if (w_hs) begin
          wr_state_nxt = WR_HAVE_DATA;
        end
      end
      WR_HAVE_ADDR: begin
        if (w_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end
      end
      WR_HAVE_DATA: begin
        if (aw_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rd_state_nxt = rd_state;
    if (rd_state == RD_IDLE) begin
      if (ar_hs) rd_state_nxt = RD_RESP;
    end else begin
      if (rready) rd_state_nxt = RD_IDLE;
    end
  end

  // State registers for both channels.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // Hold the first-arriving AW or W until its partner shows up.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Response codes are latched at acceptance and held while valid is up.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      if (wr_commit) bresp_q <= aw_hit ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs)     rresp_q <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_lite_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regbank (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .wr_en    (wr_commit && aw_hit),
    .wr_idx   (aw_word[IDX_W-1:0]),
    .wr_data  (wr_data_eff),
    .wr_strb  (wr_strb_eff),
    .rd_en    (ar_hs),
    .rd_hit   (ar_hit),
    .rd_idx   (ar_word[IDX_W-1:0]),
    .rd_data  (rdata),
    .reg_q    (reg_q),
    .wr_pulse (reg_wr_pulse)
  );

endmodule

// File: tb/tb_axi_lite_regbank_slave.sv
// Bench for axi_lite_regbank_slave: vector table, corner sequences, random traffic vs a register-array model.
module tb_axi_lite_regbank_slave;

  localparam int NR = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [NR];

  always #5 aclk = ~aclk;

  axi_lite_regbank_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;     // >0: W leads AW by this many cycles, <0: AW leads
    int          dly;      // cycles bready/rready held low
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < 32'(NR);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return in_range(a) ? mdl[a >> 2] : 32'h0;
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a >> 2][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  task automatic check_regq(input string name);
    for (int i = 0; i < NR; i++) check(name, reg_q[i*32 +: 32], mdl[i]);
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  task automatic wait_rdy(input int which);
    int n = 0;
    while (!rdy(which) && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL ready_timeout: channel %0d never ready, want 1", which);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int dly, input logic [1:0] exp_resp);
    int gap;
    logic [7:0] exp_pulse;
    gap = (lead < 0) ? -lead : lead;
    exp_pulse = in_range(a) ? 8'(1 << (a >> 2)) : 8'h00;
    awaddr = a; wdata = d; wstrb = s;
    if (lead >= 0) wvalid = 1'b1;
    if (lead <= 0) awvalid = 1'b1;
    wait_rdy((lead > 0) ? 1 : 0);
    @(posedge aclk); #1;
    if (lead != 0) begin
      if (lead > 0) begin
        wvalid = 1'b0;
        check("have_data_awready", 32'(awready), 32'd1);
        check("have_data_wready",  32'(wready),  32'd0);
      end else begin
        awvalid = 1'b0;
        check("have_addr_awready", 32'(awready), 32'd0);
        check("have_addr_wready",  32'(wready),  32'd1);
      end
      check("partial_no_bvalid", 32'(bvalid), 32'd0);
      repeat (gap - 1) begin @(posedge aclk); #1; end
      if (lead > 0) awvalid = 1'b1; else wvalid = 1'b1;
      wait_rdy((lead > 0) ? 0 : 1);
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_latency", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_resp));
    check("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
    mdl_write(a, d, s);
    check_regq("reg_q_after_write");
    for (int i = 0; i < dly; i++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bresp_hold", 32'(bresp), 32'(exp_resp));
      check("pulse_one_cycle", 32'(reg_wr_pulse), 32'd0);
      check("ready_in_resp", 32'({awready, wready}), 32'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("pulse_clear", 32'(reg_wr_pulse), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int dly,
                         input logic [31:0] exp_d, input logic [1:0] exp_r);
    araddr = a; arvalid = 1'b1;
    wait_rdy(2);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rvalid_latency", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp_d);
    check("rresp", 32'(rresp), 32'(exp_r));
    for (int i = 0; i < dly; i++) begin
      @(posedge aclk); #1;
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_d);
      check("arready_busy", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    //            rd  addr          data          strb  lead dly exp_data      resp
    vt[0]  = '{1'b0, 32'h04, 32'hDEADBEEF, 4'hF,  0, 0, 32'h0,        2'b00};
    vt[1]  = '{1'b0, 32'h08, 32'h11223344, 4'hF,  0, 1, 32'h0,        2'b00};
    vt[2]  = '{1'b0, 32'h08, 32'hAAAA5555, 4'h3,  3, 0, 32'h0,        2'b00};
    vt[3]  = '{1'b1, 32'h08, 32'h0,        4'h0,  0, 0, 32'h11225555, 2'b00};
    vt[4]  = '{1'b0, 32'h40, 32'hFFFFFFFF, 4'hF,  0, 0, 32'h0,        2'b10};
    vt[5]  = '{1'b1, 32'h40, 32'h0,        4'h0,  0, 0, 32'h00000000, 2'b10};
    vt[6]  = '{1'b0, 32'h1C, 32'hCAFEF00D, 4'hC, -2, 2, 32'h0,        2'b00};
    vt[7]  = '{1'b1, 32'h1F, 32'h0,        4'h0,  0, 0, 32'hCAFE0000, 2'b00};
    vt[8]  = '{1'b0, 32'h10, 32'h55555555, 4'h0,  0, 0, 32'h0,        2'b00};
    vt[9]  = '{1'b1, 32'h10, 32'h0,        4'h0,  0, 0, 32'h00000000, 2'b00};
    vt[10] = '{1'b1, 32'h20, 32'h0,        4'h0,  0, 0, 32'h00000000, 2'b10};
    vt[11] = '{1'b0, 32'h20, 32'h12345678, 4'hF,  1, 0, 32'h0,        2'b10};
    vt[12] = '{1'b1, 32'h07, 32'h0,        4'h0,  0, 2, 32'hDEADBEEF, 2'b00};

    aresetn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;

    #12;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_pulse",   32'(reg_wr_pulse), 32'd0);
    check_regq("rst_reg_q");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].is_rd) do_read(vt[i].addr, vt[i].dly, vt[i].exp_data, vt[i].exp_resp);
      else do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].lead, vt[i].dly, vt[i].exp_resp);
    end

    // Read held off for five cycles.
    do_read(32'h04, 5, 32'hDEADBEEF, 2'b00);

    // Read and write commit to the same register on the same edge.
    awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_bvalid", 32'(bvalid), 32'd1);
    check("same_edge_rvalid", 32'(rvalid), 32'd1);
    check("same_edge_old_rdata", rdata, 32'h00000000);
    check("same_edge_new_reg", reg_q[3*32 +: 32], 32'h12345678);
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    mdl_write(32'h0C, 32'h12345678, 4'hF);
    do_read(32'h0C, 0, 32'h12345678, 2'b00);

    // Reset while an AW is held waiting for W.
    awaddr = 32'h04; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("pre_rst_awready", 32'(awready), 32'd0);
    aresetn = 1'b0;
    #2;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    check("mid_rst_awready", 32'(awready), 32'd1);
    check("mid_rst_wready",  32'(wready),  32'd1);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_bvalid",  32'(bvalid),  32'd0);
    check_regq("mid_rst_reg_q");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_wready",  32'(wready),  32'd1);
    check("post_rst_bvalid",  32'(bvalid),  32'd0);
    check_regq("post_rst_reg_q");
    // W alone must not complete a write: the captured AW was discarded.
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    check("discarded_aw_bvalid", 32'(bvalid), 32'd0);
    check("discarded_aw_wready", 32'(wready), 32'd0);
    awaddr = 32'h00; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("late_aw_bvalid", 32'(bvalid), 32'd1);
    mdl_write(32'h00, 32'h0BADF00D, 4'hF);
    check_regq("late_aw_reg_q");
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;

    // Random traffic against the register-array model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int          lead, dly;
      a    = $urandom_range(0, 32'h27);
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      lead = $urandom_range(0, 6) - 3;
      dly  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        do_read(a, dly, mdl_read(a), in_range(a) ? 2'b00 : 2'b10);
      else
        do_write(a, d, s, lead, dly, in_range(a) ? 2'b00 : 2'b10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
